// File: rtl/jpeg_pkg.sv
// Shared types and constants for the Y/Cb/Cr stream arbiter slice.
package jpeg_pkg;

   localparam int FULL_WORD_BITS = 32;

   localparam logic [1:0] CHAN_Y  = 2'd0;
   localparam logic [1:0] CHAN_CB = 2'd1;
   localparam logic [1:0] CHAN_CR = 2'd2;

   typedef enum logic [1:0] {
      S_Y  = 2'd0,
      S_CB = 2'd1,
      S_CR = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic [31:0] data;
      logic [5:0]  bits;
      logic        last;
   } ycc_entry_t;

   // A simultaneous data_ready/eob_empty collapses into the single final entry.
   function automatic ycc_entry_t make_entry(input logic [31:0] word,
                                             input logic [4:0]  orc,
                                             input logic        eob);
      ycc_entry_t e;
      e.data = word;
      e.bits = eob ? {1'b0, orc} : 6'(FULL_WORD_BITS);
      e.last = eob;
      return e;
   endfunction

endpackage

// File: rtl/ycc_stream_arbiter_if.sv
// Merged output stream of the Y/Cb/Cr arbiter: MSB-aligned word plus sideband.
interface ycc_stream_arbiter_if;
   logic [31:0] out_data;
   logic [5:0]  out_bits;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_chan;
   logic        out_last;

   modport master (output out_data, out_bits, out_valid, out_chan, out_last,
                   input  out_ready);
   modport slave  (input  out_data, out_bits, out_valid, out_chan, out_last,
                   output out_ready);
endinterface

// File: rtl/ycc_entry_fifo.sv
// Synchronous entry FIFO with an extra pointer MSB separating full from empty.
module ycc_entry_fifo
   import jpeg_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  ycc_entry_t               push_entry,
   input  logic                     pop,
   output ycc_entry_t               head,
   output logic                     drop,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   ycc_entry_t mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        empty;
   logic        full;
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   // When full, a same-cycle pop frees the slot being written.
   assign do_push = push & (~full | do_pop);
   assign drop    = push & full & ~do_pop;
   assign count   = wr_ptr - rd_ptr;
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
   end

endmodule

// File: rtl/ycc_stream_arbiter.sv
// Merges per-channel Huffman words into one stream, one 8x8 block per channel in Y/Cb/Cr order.
// Optional statistics outputs (mcu_count, max_fill) are built when YCC_ARB_STATS_EN is defined.
//
//   state | meaning
//   S_Y   | emitting the Y block, waiting for its final word
//   S_CB  | emitting the Cb block, waiting for its final word
//   S_CR  | emitting the Cr block; its final word closes the MCU
module ycc_stream_arbiter
   import jpeg_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           y_JPEG_bitstream,
   input  logic [31:0]           cb_JPEG_bitstream,
   input  logic [31:0]           cr_JPEG_bitstream,
   input  logic                  y_data_ready,
   input  logic                  cb_data_ready,
   input  logic                  cr_data_ready,
   input  logic [4:0]            y_orc,
   input  logic [4:0]            cb_orc,
   input  logic [4:0]            cr_orc,
   input  logic                  y_eob_empty,
   input  logic                  cb_eob_empty,
   input  logic                  cr_eob_empty,
   ycc_stream_arbiter_if.master  out_if,
   output logic                  overflow
`ifdef YCC_ARB_STATS_EN
   ,
   output logic [15:0]           mcu_count,
   output logic [6:0]            max_fill
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   arb_state_e  state;
   logic [31:0] word [3];
   logic [4:0]  orc [3];
   logic [2:0]  dr;
   logic [2:0]  eob;
   logic [2:0]  push;
   logic [2:0]  pop;
   logic [2:0]  drop;
   ycc_entry_t  push_entry [3];
   ycc_entry_t  head [3];
   logic [CW-1:0] fill [3];

   logic [1:0]  sel;
   ycc_entry_t  sel_head;
   logic        valid;
   logic        last;
   logic        handshake;

   assign word[0] = y_JPEG_bitstream;
   assign word[1] = cb_JPEG_bitstream;
   assign word[2] = cr_JPEG_bitstream;
   assign orc[0]  = y_orc;
   assign orc[1]  = cb_orc;
   assign orc[2]  = cr_orc;
   assign dr      = {cr_data_ready, cb_data_ready, y_data_ready};
   assign eob     = {cr_eob_empty, cb_eob_empty, y_eob_empty};

   for (genvar i = 0; i < 3; i++) begin : g_chan
      assign push[i]       = (dr[i] | eob[i]) & ~rst;
      assign push_entry[i] = make_entry(word[i], orc[i], eob[i]);

      ycc_entry_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .clk        (clk),
         .rst        (rst),
         .push       (push[i]),
         .push_entry (push_entry[i]),
         .pop        (pop[i]),
         .head       (head[i]),
         .drop       (drop[i]),
         .count      (fill[i])
      );
   end

   always_comb begin
      sel      = CHAN_Y;
      sel_head = head[0];
      case (state)
         S_CB: begin sel = CHAN_CB; sel_head = head[1]; end
         S_CR: begin sel = CHAN_CR; sel_head = head[2]; end
         default: begin sel = CHAN_Y; sel_head = head[0]; end
      endcase
   end

   assign valid     = (fill[sel] != '0);
   assign last      = valid & sel_head.last & (state == S_CR);
   assign handshake = valid & out_if.out_ready;
   assign pop       = handshake ? (3'b001 << sel) : 3'b000;

   // Masking with valid keeps the outputs at zero while empty and after reset.
   assign out_if.out_valid = valid;
   assign out_if.out_data  = valid ? sel_head.data : '0;
   assign out_if.out_bits  = valid ? sel_head.bits : '0;
   assign out_if.out_chan  = valid ? sel : '0;
   assign out_if.out_last  = last;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_Y;
      end else if (handshake && sel_head.last) begin
         case (state)
            S_Y:     state <= S_CB;
            S_CB:    state <= S_CR;
            default: state <= S_Y;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)        overflow <= 1'b0;
      else if (|drop) overflow <= 1'b1;
   end

`ifdef YCC_ARB_STATS_EN
   logic [6:0] peak;

   always_comb begin
      peak = 7'(fill[0]);
      if (7'(fill[1]) > peak) peak = 7'(fill[1]);
      if (7'(fill[2]) > peak) peak = 7'(fill[2]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcu_count <= '0;
         max_fill  <= '0;
      end else begin
         if (handshake && last) mcu_count <= mcu_count + 16'd1;
         if (peak > max_fill)   max_fill  <= peak;
      end
   end
`endif

endmodule

// File: tb/tb_ycc_stream_arbiter.sv
// Directed bench for ycc_stream_arbiter: ordering, latency, overflow, stalls and reset.
module tb_ycc_stream_arbiter;
   import jpeg_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] y_word, cb_word, cr_word;
   logic        y_dr, cb_dr, cr_dr;
   logic [4:0]  y_orc, cb_orc, cr_orc;
   logic        y_eob, cb_eob, cr_eob;
   logic        overflow;
`ifdef YCC_ARB_STATS_EN
   logic [15:0] mcu_count;
   logic [6:0]  max_fill;
`endif

   ycc_stream_arbiter_if arb_if();

   int checks = 0;
   int errors = 0;

   logic [31:0] got_data [32];
   logic [5:0]  got_bits [32];
   logic [1:0]  got_chan [32];
   logic        got_last [32];
   int          got_n;

   always #5 clk = ~clk;

   ycc_stream_arbiter #(.FIFO_DEPTH(16)) dut (
      .clk               (clk),
      .rst               (rst),
      .y_JPEG_bitstream  (y_word),
      .cb_JPEG_bitstream (cb_word),
      .cr_JPEG_bitstream (cr_word),
      .y_data_ready      (y_dr),
      .cb_data_ready     (cb_dr),
      .cr_data_ready     (cr_dr),
      .y_orc             (y_orc),
      .cb_orc            (cb_orc),
      .cr_orc            (cr_orc),
      .y_eob_empty       (y_eob),
      .cb_eob_empty      (cb_eob),
      .cr_eob_empty      (cr_eob),
      .out_if            (arb_if.master),
      .overflow          (overflow)
`ifdef YCC_ARB_STATS_EN
      ,
      .mcu_count         (mcu_count),
      .max_fill          (max_fill)
`endif
   );

   task automatic clear_inputs();
      y_word = '0; cb_word = '0; cr_word = '0;
      y_dr = 0; cb_dr = 0; cr_dr = 0;
      y_eob = 0; cb_eob = 0; cr_eob = 0;
      y_orc = '0; cb_orc = '0; cr_orc = '0;
   endtask

   // Called at a falling edge; the push lands on the next rising edge.
   task automatic push(input int ch, input logic [31:0] w, input logic d,
                       input logic e, input logic [4:0] o);
      case (ch)
         0: begin y_word = w;  y_dr = d;  y_eob = e;  y_orc = o;  end
         1: begin cb_word = w; cb_dr = d; cb_eob = e; cb_orc = o; end
         default: begin cr_word = w; cr_dr = d; cr_eob = e; cr_orc = o; end
      endcase
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Accepts up to n words with out_ready high, recording each accepted word.
   task automatic drain(input int n, input int budget);
      got_n = 0;
      for (int c = 0; c < budget && got_n < n; c++) begin
         arb_if.out_ready = 1'b1;
         if (arb_if.out_valid) begin
            got_data[got_n] = arb_if.out_data;
            got_bits[got_n] = arb_if.out_bits;
            got_chan[got_n] = arb_if.out_chan;
            got_last[got_n] = arb_if.out_last;
            got_n++;
         end
         @(negedge clk);
      end
      arb_if.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++; if (arb_if.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", arb_if.out_valid); end
      checks++; if (arb_if.out_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 0", arb_if.out_data); end
      checks++; if (arb_if.out_bits !== 6'd0) begin errors++; $display("FAIL rst_bits got %0d want 0", arb_if.out_bits); end
      checks++; if (arb_if.out_chan !== 2'd0) begin errors++; $display("FAIL rst_chan got %0d want 0", arb_if.out_chan); end
      checks++; if (arb_if.out_last !== 1'b0) begin errors++; $display("FAIL rst_last got %b want 0", arb_if.out_last); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", overflow); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (dut.state !== S_Y) begin errors++; $display("FAIL rst_state got %0d want 0", dut.state); end
      checks++; if (arb_if.out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", arb_if.out_valid); end
   endtask

   task automatic test_sequence();
      logic [31:0] exp_data [6] = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003,
                                    32'hB000_0001, 32'hC000_0001, 32'hC000_0002};
      int exp_chan [6] = '{0, 0, 0, 1, 2, 2};
      int exp_bits [6] = '{32, 32, 7, 12, 32, 0};
      int exp_last [6] = '{0, 0, 0, 0, 0, 1};
      push(0, exp_data[0], 1, 0, 5'd0);
      push(0, exp_data[1], 1, 0, 5'd0);
      push(0, exp_data[2], 0, 1, 5'd7);
      push(1, exp_data[3], 0, 1, 5'd12);
      push(2, exp_data[4], 1, 0, 5'd0);
      push(2, exp_data[5], 0, 1, 5'd0);
      drain(6, 40);
      checks++; if (got_n != 6) begin errors++; $display("FAIL seq_count got %0d want 6", got_n); end
      for (int i = 0; i < 6 && i < got_n; i++) begin
         checks++; if (got_chan[i] !== 2'(exp_chan[i])) begin errors++; $display("FAIL seq_chan[%0d] got %0d want %0d", i, got_chan[i], exp_chan[i]); end
         checks++; if (got_bits[i] !== 6'(exp_bits[i])) begin errors++; $display("FAIL seq_bits[%0d] got %0d want %0d", i, got_bits[i], exp_bits[i]); end
         checks++; if (got_last[i] !== 1'(exp_last[i])) begin errors++; $display("FAIL seq_last[%0d] got %b want %0d", i, got_last[i], exp_last[i]); end
         checks++; if (got_data[i] !== exp_data[i]) begin errors++; $display("FAIL seq_data[%0d] got %h want %h", i, got_data[i], exp_data[i]); end
      end
      checks++; if (arb_if.out_valid !== 1'b0) begin errors++; $display("FAIL seq_empty got %b want 0", arb_if.out_valid); end
      checks++; if (dut.state !== S_Y) begin errors++; $display("FAIL seq_state got %0d want 0", dut.state); end
   endtask

   task automatic test_empty_wait();
      push(1, 32'hB111_0000, 0, 1, 5'd3);
      checks++; if (arb_if.out_valid !== 1'b0) begin errors++; $display("FAIL wait_cb got %b want 0", arb_if.out_valid); end
      push(2, 32'hC222_0000, 0, 1, 5'd4);
      checks++; if (arb_if.out_valid !== 1'b0) begin errors++; $display("FAIL wait_cr got %b want 0", arb_if.out_valid); end
      repeat (3) @(negedge clk);
      checks++; if (arb_if.out_valid !== 1'b0) begin errors++; $display("FAIL wait_idle got %b want 0", arb_if.out_valid); end
      y_word = 32'hA333_0000; y_eob = 1'b1; y_orc = 5'd9;
      checks++; if (arb_if.out_valid !== 1'b0) begin errors++; $display("FAIL wait_pre_edge got %b want 0", arb_if.out_valid); end
      @(negedge clk);
      clear_inputs();
      checks++; if (arb_if.out_valid !== 1'b1) begin errors++; $display("FAIL wait_latency got %b want 1", arb_if.out_valid); end
      checks++; if (arb_if.out_bits !== 6'd9) begin errors++; $display("FAIL wait_y_bits got %0d want 9", arb_if.out_bits); end
      drain(3, 20);
      checks++; if (got_n != 3) begin errors++; $display("FAIL wait_count got %0d want 3", got_n); end
      checks++; if (got_chan[0] !== 2'd0 || got_chan[1] !== 2'd1 || got_chan[2] !== 2'd2) begin
         errors++; $display("FAIL wait_chans got %0d %0d %0d want 0 1 2", got_chan[0], got_chan[1], got_chan[2]); end
      checks++; if (got_bits[1] !== 6'd3 || got_bits[2] !== 6'd4) begin
         errors++; $display("FAIL wait_bits got %0d %0d want 3 4", got_bits[1], got_bits[2]); end
      checks++; if (got_last[2] !== 1'b1 || got_last[0] !== 1'b0) begin
         errors++; $display("FAIL wait_last got %b %b want 0 1", got_last[0], got_last[2]); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 17; i++) begin
         push(0, 32'h0000_0100 + 32'(i), 1, 0, 5'd0);
         if (i == 15) begin
            checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_full got %b want 0", overflow); end
         end
      end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
      drain(17, 60);
      checks++; if (got_n != 16) begin errors++; $display("FAIL ovf_drained got %0d want 16", got_n); end
      for (int i = 0; i < 16 && i < got_n; i++) begin
         checks++; if (got_data[i] !== 32'h0000_0100 + 32'(i)) begin
            errors++; $display("FAIL ovf_data[%0d] got %h want %h", i, got_data[i], 32'h0000_0100 + 32'(i)); end
      end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
   endtask

   task automatic test_reset_mid();
      push(0, 32'hD000_0000, 0, 1, 5'd1);
      push(1, 32'hE000_0000, 0, 1, 5'd2);
      push(2, 32'hF000_0000, 1, 0, 5'd0);
      push(2, 32'hF000_0001, 1, 0, 5'd0);
      push(2, 32'hF000_0002, 0, 1, 5'd3);
      drain(2, 20);
      checks++; if (dut.state !== S_CR) begin errors++; $display("FAIL mid_state_cr got %0d want 2", dut.state); end
      checks++; if (arb_if.out_valid !== 1'b1 || arb_if.out_chan !== 2'd2) begin
         errors++; $display("FAIL mid_pending got valid %b chan %0d want 1 2", arb_if.out_valid, arb_if.out_chan); end
      rst = 1'b1;
      y_word = 32'h1234_5678; y_dr = 1'b1;
      @(negedge clk);
      clear_inputs();
      checks++; if (arb_if.out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", arb_if.out_valid); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got %b want 0", overflow); end
      checks++; if (dut.state !== S_Y) begin errors++; $display("FAIL mid_state got %0d want 0", dut.state); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (arb_if.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_push got %b want 0", arb_if.out_valid); end
      push(1, 32'h6666_0000, 1, 0, 5'd0);
      push(0, 32'h7777_0000, 1, 0, 5'd0);
      drain(1, 10);
      checks++; if (got_n != 1 || got_chan[0] !== 2'd0 || got_data[0] !== 32'h7777_0000) begin
         errors++; $display("FAIL mid_first_y got n %0d chan %0d data %h want 1 0 77770000", got_n, got_chan[0], got_data[0]); end
      do_reset();
   endtask

   task automatic test_both_pulses();
      y_word = 32'h5555_AAAA; y_dr = 1'b1; y_eob = 1'b1; y_orc = 5'd5;
      @(negedge clk);
      clear_inputs();
      checks++; if (arb_if.out_valid !== 1'b1 || arb_if.out_bits !== 6'd5) begin
         errors++; $display("FAIL both_head got valid %b bits %0d want 1 5", arb_if.out_valid, arb_if.out_bits); end
      drain(1, 10);
      checks++; if (got_data[0] !== 32'h5555_AAAA || got_last[0] !== 1'b0) begin
         errors++; $display("FAIL both_word got %h last %b want 5555aaaa 0", got_data[0], got_last[0]); end
      checks++; if (arb_if.out_valid !== 1'b0) begin errors++; $display("FAIL both_single got %b want 0", arb_if.out_valid); end
      checks++; if (dut.state !== S_CB) begin errors++; $display("FAIL both_state got %0d want 1", dut.state); end
      do_reset();
   endtask

   task automatic test_stall();
      logic [31:0] exp_data [6] = '{32'h1100_0001, 32'h1100_0002, 32'h1100_0003,
                                    32'h2200_0001, 32'h3300_0001, 32'h3300_0002};
      int exp_chan [6] = '{0, 0, 0, 1, 2, 2};
      int exp_bits [6] = '{32, 32, 7, 12, 32, 0};
      int exp_last [6] = '{0, 0, 0, 0, 0, 1};
      logic        prev_stall = 1'b0;
      logic [31:0] pd = '0;
      logic [5:0]  pb = '0;
      logic [1:0]  pc = '0;
      logic        pl = 1'b0;
      int          got = 0;
      push(0, exp_data[0], 1, 0, 5'd0);
      push(0, exp_data[1], 1, 0, 5'd0);
      push(0, exp_data[2], 0, 1, 5'd7);
      push(1, exp_data[3], 0, 1, 5'd12);
      push(2, exp_data[4], 1, 0, 5'd0);
      push(2, exp_data[5], 0, 1, 5'd0);
      for (int c = 0; c < 300 && got < 6; c++) begin
         arb_if.out_ready = 1'($urandom_range(0, 1));
         if (prev_stall) begin
            checks++;
            if (arb_if.out_valid !== 1'b1 || arb_if.out_data !== pd || arb_if.out_bits !== pb ||
                arb_if.out_chan !== pc || arb_if.out_last !== pl) begin
               errors++; $display("FAIL stall_hold got %h/%0d/%0d/%b want %h/%0d/%0d/%b",
                  arb_if.out_data, arb_if.out_bits, arb_if.out_chan, arb_if.out_last, pd, pb, pc, pl);
            end
         end
         if (arb_if.out_valid && arb_if.out_ready) begin
            checks++;
            if (arb_if.out_data !== exp_data[got] || arb_if.out_bits !== 6'(exp_bits[got]) ||
                arb_if.out_chan !== 2'(exp_chan[got]) || arb_if.out_last !== 1'(exp_last[got])) begin
               errors++; $display("FAIL stall_word[%0d] got %h/%0d/%0d/%b want %h/%0d/%0d/%0d", got,
                  arb_if.out_data, arb_if.out_bits, arb_if.out_chan, arb_if.out_last,
                  exp_data[got], exp_bits[got], exp_chan[got], exp_last[got]);
            end
            got++;
         end
         prev_stall = arb_if.out_valid & ~arb_if.out_ready;
         pd = arb_if.out_data; pb = arb_if.out_bits; pc = arb_if.out_chan; pl = arb_if.out_last;
         @(negedge clk);
      end
      arb_if.out_ready = 1'b0;
      checks++; if (got != 6) begin errors++; $display("FAIL stall_count got %0d want 6", got); end
      checks++; if (arb_if.out_valid !== 1'b0) begin errors++; $display("FAIL stall_dup got %b want 0", arb_if.out_valid); end
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      arb_if.out_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_sequence();
      test_empty_wait();
      test_overflow();
      test_reset_mid();
      test_both_pulses();
      test_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ycc_stream_arbiter.md
YCC_STREAM_ARBITER -- requirements
Module: ycc_stream_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, is the entries per channel FIFO; it SHALL be a power of two, 4..64.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 y_JPEG_bitstream / cb_JPEG_bitstream / cr_JPEG_bitstream  input  32 each  per-channel packed Huffman word, MSB-first.
REQ-005 y_data_ready / cb_data_ready / cr_data_ready  input  1 each  one-cycle pulse: the channel word is a full 32-bit word.
REQ-006 y_orc / cb_orc / cr_orc  input  5 each  valid-bit count of the channel's final partial word.
REQ-007 y_eob_empty / cb_eob_empty / cr_eob_empty  input  1 each  one-cycle pulse: end of the 8x8 block; the channel word is the final partial word.
REQ-008 out_data  output  32  merged stream word, MSB-aligned.
REQ-009 out_bits  output  6  valid bits in out_data, 0..32.
REQ-010 out_valid  output  1  out_data, out_bits, out_last and out_chan are valid.
REQ-011 out_ready  input  1  downstream accepts the word when out_valid & out_ready.
REQ-012 out_chan  output  2  source channel: 0=Y, 1=Cb, 2=Cr.
REQ-013 out_last  output  1  word is the Cr final word of an MCU.
REQ-014 overflow  output  1  sticky: an entry was dropped.

Function
REQ-015 Each channel SHALL own a FIFO of FIFO_DEPTH entries {data[31:0], bits[5:0], last}.
REQ-016 A data_ready pulse SHALL push {word, 32, 0}.
REQ-017 An eob_empty pulse SHALL push {word, orc, 1}.
REQ-018 When data_ready and eob_empty are high together, the block SHALL push exactly one entry, {word, orc, 1}.
REQ-019 A push to a full FIFO SHALL drop that entry, leave the FIFO contents unchanged and set overflow.
REQ-020 overflow SHALL clear only on rst.
REQ-021 The FSM SHALL have the states S_Y, S_CB and S_CR, selecting the head of the Y, Cb or Cr FIFO respectively.
REQ-022 out_valid SHALL equal "selected FIFO not empty"; out_data, out_bits and out_chan SHALL come from the selected head.
REQ-023 A word pushed into the empty selected FIFO at clock edge k SHALL appear on out_valid after edge k (1-cycle latency).
REQ-024 On a handshake the selected FIFO SHALL pop; if the popped entry has last=1, the state SHALL advance S_Y->S_CB->S_CR->S_Y; otherwise it SHALL stay.
REQ-025 out_last SHALL equal head.last & (state==S_CR).
REQ-026 While out_valid=1 and out_ready=0, all out_* signals SHALL hold stable.
REQ-027 A push and a pop on the same FIFO in the same cycle SHALL both take effect, with the count unchanged; a full FIFO with a simultaneous pop SHALL accept the push.
REQ-028 A final entry with orc=0 SHALL still be emitted (out_bits=0) so that the channel rotation advances.
REQ-029 Non-selected FIFOs SHALL keep accepting pushes independently.
REQ-030 Read and write pointers SHALL wrap modulo FIFO_DEPTH, with an extra MSB used to distinguish full from empty.

Reset
REQ-031 On rst the block SHALL empty all FIFOs, set state=S_Y and set overflow=0.
REQ-032 On rst, out_valid=0, out_last=0, out_chan=0, out_bits=0 and out_data=0 SHALL result.
REQ-033 rst asserted mid-block SHALL discard all partial blocks; the first post-reset word SHALL be taken from Y.
REQ-034 Pushes in the same cycle as rst SHALL be ignored.

Configuration
REQ-035 With YCC_ARB_STATS_EN defined, the block SHALL add output mcu_count[15:0], incremented on each out_last handshake, wrapping 0xFFFF->0, and reset to 0.
REQ-036 With YCC_ARB_STATS_EN defined, the block SHALL add output max_fill[6:0], the peak occupancy over all FIFOs since reset.
REQ-037 Without YCC_ARB_STATS_EN, neither port nor its logic SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-038 Package jpeg_pkg SHALL hold the entry struct typedef, the state enum (S_Y, S_CB, S_CR), the channel codes and the constant FULL_WORD_BITS=32.
REQ-039 There SHALL be one sub-module, ycc_entry_fifo (a synchronous FIFO, parameterised depth), instantiated three times; the arbiter FSM and output muxing SHALL live at top level.

Verification
REQ-040 The bench SHALL apply Y: 2 full words + final word orc=7, Cb: final word only orc=12, Cr: 1 full word + final word orc=0, with out_ready=1, and check the sequence chan 0,0,0,1,2,2, bits 32,32,7,12,32,0, with out_last only on the sixth word.
REQ-041 The bench SHALL push Cb and Cr blocks before any Y word and check that out_valid stays 0 until the first Y push, then appears 1 cycle later.
REQ-042 The bench SHALL hold out_ready=0 with FIFO_DEPTH=16 and push 17 Y words, and check that overflow=1 and that exactly 16 words drain in order once out_ready=1.
REQ-043 The bench SHALL drive data_ready and eob_empty together on Y with orc=5, and check that a single entry with bits=5 is emitted and the state moves to S_CB.
REQ-044 The bench SHALL toggle out_ready randomly during the 3-channel block and check that out_* stay stable while stalled, with no loss or duplication.
REQ-045 The bench SHALL assert rst while in S_CR with 3 entries pending, and check that out_valid=0, overflow=0 and state S_Y on the next cycle, and that a new Y word is emitted first.
